// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: widths, reset PC,
// FSM state encoding and the buffered fetch-entry layout.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and same-cycle push+pop in any occupancy,
// including full-with-pop. The head reads as zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // NOTE: storage is not reset; the head is gated to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count == (AW+1)'(DEPTH - 1));
  assign empty       = (count == '0);
  assign head        = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Byte-serial instruction fetch: assembles little-endian 32-bit words from a
// byte-wide memory, buffers {pc, insn} for decode and honours redirects.
module insn_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_en,
  output logic [XLEN-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  output logic            insn_valid,
  output logic [ILEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc,
  input  logic            insn_ready,
  output logic            fetch_err
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [XLEN-1:0] pc;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_lo;
  logic            pop;
  logic            push;
  logic            misaligned;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_almost_full;
  logic            full_after_push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign pop             = insn_valid && insn_ready;
  assign push            = (state == ST_FETCH) && (byte_cnt == 2'd3) && !redirect_valid;
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign full_after_push = pop ? fifo_full : fifo_almost_full;

  // The top byte bypasses the assembly register and goes straight into the push.
  assign push_entry.pc   = pc;
  assign push_entry.insn = {mem_rdata, asm_lo};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .push        (push),
    .push_data   (push_entry),
    .pop         (pop),
    .head        (head_entry),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full)
  );

  assign insn_valid = !fifo_empty;
  assign insn       = head_entry.insn;
  assign insn_pc    = head_entry.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (redirect_valid) begin
      state_next = misaligned ? ST_ERROR : (fetch_en ? ST_FETCH : ST_IDLE);
    end else begin
      case (state)
        ST_IDLE:  if (fetch_en) state_next = ST_FETCH;
        ST_FETCH: begin
          if (byte_cnt == 2'd3) begin
            if (full_after_push) state_next = ST_STALL;
            else if (!fetch_en)  state_next = ST_IDLE;
          end
        end
        ST_STALL: if (pop) state_next = fetch_en ? ST_FETCH : ST_IDLE;
        ST_ERROR: state_next = ST_ERROR;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en   = (state == ST_FETCH);
    mem_addr = mem_en ? pc + {{(XLEN-2){1'b0}}, byte_cnt} : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      byte_cnt  <= 2'd0;
      asm_lo    <= '0;
      fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      byte_cnt  <= 2'd0;
      asm_lo    <= '0;
      fetch_err <= misaligned;
    end else if (state == ST_FETCH) begin
      case (byte_cnt)
        2'd0:    asm_lo[7:0]   <= mem_rdata;
        2'd1:    asm_lo[15:8]  <= mem_rdata;
        2'd2:    asm_lo[23:16] <= mem_rdata;
        default: asm_lo        <= '0;
      endcase
      if (byte_cnt == 2'd3) pc <= pc + 64'd4;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: a queue-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_insn_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_en;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        insn_valid;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        insn_ready;
  logic        fetch_err;

  logic [7:0] mem_bytes [256];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  insn_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = mem_bytes[mem_addr[7:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0];
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    return {mem_bytes[b3], mem_bytes[b2], mem_bytes[b1], mem_bytes[b0]};
  endfunction

  // Behavioural model: fetching / waiting-for-space / error flags, a byte
  // counter and a queue of buffered words read straight from the memory image.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t      q[$];
  logic [63:0] m_pc       = RESET_PC;
  int          m_k        = 0;
  bit          m_fetching = 1'b0;
  bit          m_waiting  = 1'b0;
  bit          m_err      = 1'b0;
  bit          m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pc = RESET_PC; m_k = 0;
      m_fetching = 1'b0; m_waiting = 1'b0; m_err = 1'b0;
    end else begin
      m_pop = (q.size() > 0) && insn_ready;
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc; m_k = 0; m_waiting = 1'b0;
        m_err = (redirect_pc[1:0] != 2'b00);
        m_fetching = !m_err && fetch_en;
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_err) begin
          m_fetching = 1'b0;
        end else if (m_fetching) begin
          if (m_k == 3) begin
            q.push_back('{m_pc, word_at(m_pc)});
            m_pc = m_pc + 64'd4;
            m_k = 0;
            if (q.size() == DEPTH) begin
              m_fetching = 1'b0; m_waiting = 1'b1;
            end else begin
              m_fetching = fetch_en;
            end
          end else begin
            m_k++;
          end
        end else if (m_waiting) begin
          if (m_pop) begin
            m_waiting = 1'b0; m_fetching = fetch_en;
          end
        end else begin
          m_fetching = fetch_en;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_mem_en", mem_en, m_fetching);
      check("m_mem_addr", mem_addr, m_fetching ? m_pc + 64'(m_k) : m_pc);
      check("m_fetch_err", fetch_err, m_err);
      check("m_insn_valid", insn_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("m_insn", insn, q[0].insn);
        check("m_insn_pc", insn_pc, q[0].pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; fetch_en = 1'b0; insn_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_insn_valid", insn_valid, 0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    tick(); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_head(input logic [63:0] pc_exp, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (insn_valid && insn_pc == pc_exp) begin
        at = cyc;
        break;
      end
    end
    check("head_seen", at >= 0, 1);
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, c;
    logic [63:0] targets [4];
    targets[0] = 64'h80; targets[1] = 64'h06; targets[2] = 64'h0C; targets[3] = 64'hFC;

    rst_n = 1'b0; fetch_en = 1'b0; insn_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i) ^ 8'h5A;
    mem_bytes[0] = 8'h13; mem_bytes[1] = 8'h05; mem_bytes[2] = 8'h10; mem_bytes[3] = 8'h00;
    mem_bytes[4] = 8'h93; mem_bytes[5] = 8'h05; mem_bytes[6] = 8'h20; mem_bytes[7] = 8'h00;

    // First two words, 4-cycle spacing
    do_reset();
    c = cyc;
    fetch_en = 1'b1; insn_ready = 1'b1;
    wait_head(64'h0, t1);
    check("a_insn0", insn, 32'h00100513);
    check("a_latency", 64'(t1 - c), 5);
    wait_head(64'h4, t2);
    check("a_insn1", insn, 32'h00200593);
    check("a_spacing", 64'(t2 - t1), 4);

    // Back-pressure: stall with a stable head, one pop resumes at pc=8
    do_reset();
    fetch_en = 1'b1; insn_ready = 1'b0;
    repeat (14) tick();
    check("b_stall_mem_en", mem_en, 0);
    check("b_stall_addr", mem_addr, 64'h8);
    check("b_head_pc", insn_pc, 64'h0);
    check("b_head_insn", insn, 32'h00100513);
    insn_ready = 1'b1;
    tick();
    insn_ready = 1'b0;
    check("b_resume_mem_en", mem_en, 1);
    check("b_resume_addr", mem_addr, 64'h8);
    check("b_new_head", insn_pc, 64'h4);

    // Mid-word redirect with one buffered entry
    tick(); tick();
    c = cyc;
    redirect(64'h40);
    check("c_flush_valid", insn_valid, 0);
    wait_head(64'h40, t1);
    check("c_latency", 64'(t1 - c), 5);
    check("c_insn", insn, 32'h19181B1A);

    // Misaligned redirect, then recovery
    redirect(64'h42);
    check("d_err_set", fetch_err, 1);
    check("d_err_mem_en", mem_en, 0);
    check("d_err_valid", insn_valid, 0);
    repeat (3) tick();
    check("d_err_hold", fetch_err, 1);
    check("d_err_idle", mem_en, 0);
    redirect(64'h10);
    check("d_err_clr", fetch_err, 0);
    check("d_fetch_addr", mem_addr, 64'h10);
    wait_head(64'h10, t1);
    check("d_insn", insn, 32'h49484B4A);

    // Asynchronous reset at byte_cnt=2
    insn_ready = 1'b1;
    redirect(64'h20);
    tick(); tick();
    check("e_pre_addr", mem_addr, 64'h22);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_mem_en", mem_en, 0);
    check("e_rst_addr", mem_addr, RESET_PC);
    check("e_rst_valid", insn_valid, 0);
    check("e_rst_insn", insn, 0);
    check("e_rst_insn_pc", insn_pc, 0);
    check("e_rst_err", fetch_err, 0);
    #1 rst_n = 1'b1;
    c = cyc;
    wait_head(RESET_PC, t1);
    check("e_restart_lat", 64'(t1 - c), 5);
    check("e_restart_insn", insn, 32'h00100513);

    // fetch_en dropped at byte_cnt=1: word completes, then idle at pc+4
    insn_ready = 1'b0;
    redirect(64'h30);
    tick();
    fetch_en = 1'b0;
    repeat (4) tick();
    check("f_idle_mem_en", mem_en, 0);
    check("f_idle_addr", mem_addr, 64'h34);
    check("f_valid", insn_valid, 1);
    check("f_insn_pc", insn_pc, 64'h30);
    check("f_insn", insn, 32'h69686B6A);

    // Mixed traffic: gated fetch, intermittent ready, periodic redirects
    for (int i = 0; i < 200; i++) begin
      fetch_en   = (i % 40) < 34;
      insn_ready = (i % 3) != 0;
      if (i % 45 == 20) begin
        redirect_valid = 1'b1;
        redirect_pc    = targets[(i / 45) % 4];
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
